// File: rtl/credit_counter.sv
// credit_counter
//   Consumer-side credit tracker for credit-based flow control. Holds the
//   number of credits available to a sender, decrements on take, increments
//   on give, saturates at 0 and NUM_CREDITS and latches the illegal event.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   clear_i         synchronous re-init of count, clears error flags
//   credit_take_i   sender consumes one credit
//   credit_give_i   receiver returns one credit
//   credit_left_o   registered credit count
//   credit_avail_o  count != 0
//   credit_full_o   count == NUM_CREDITS
//   credit_crit_o   count <= CRIT_LEVEL
//   err_underflow_o sticky: take at count 0 without a same-cycle give
//   err_overflow_o  sticky: give at full count without a same-cycle take
module credit_counter #(
    parameter int NUM_CREDITS = 8,
    parameter bit INIT_FULL   = 1'b1,
    parameter int CRIT_LEVEL  = 1,
    parameter int CNT_WIDTH   = $clog2(NUM_CREDITS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 credit_take_i,
    input  logic                 credit_give_i,
    output logic [CNT_WIDTH-1:0] credit_left_o,
    output logic                 credit_avail_o,
    output logic                 credit_full_o,
    output logic                 credit_crit_o,
    output logic                 err_underflow_o,
    output logic                 err_overflow_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL  = CNT_WIDTH'(NUM_CREDITS);
    localparam logic [CNT_WIDTH-1:0] INIT_VAL = INIT_FULL ? MAX_VAL : '0;
    localparam logic [CNT_WIDTH-1:0] CRIT_VAL = CNT_WIDTH'(CRIT_LEVEL);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    generate
        if (NUM_CREDITS < 1) begin : g_bad_num
            $error("credit_counter: NUM_CREDITS must be >= 1");
        end
        if (CRIT_LEVEL >= NUM_CREDITS) begin : g_bad_crit
            $error("credit_counter: CRIT_LEVEL must be < NUM_CREDITS");
        end
    endgenerate

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count           <= INIT_VAL;
            err_underflow_o <= 1'b0;
            err_overflow_o  <= 1'b0;
        end else if (clear_i) begin
            count           <= INIT_VAL;
            err_underflow_o <= 1'b0;
            err_overflow_o  <= 1'b0;
        end else if (credit_take_i && credit_give_i) begin
            // Simultaneous take and give cancel, even at either bound.
            count <= count;
        end else if (credit_take_i) begin
            if (count != '0) begin
                count <= count - ONE;
            end else begin
                err_underflow_o <= 1'b1;
            end
        end else if (credit_give_i) begin
            if (count != MAX_VAL) begin
                count <= count + ONE;
            end else begin
                err_overflow_o <= 1'b1;
            end
        end
    end

    assign credit_left_o  = count;
    assign credit_avail_o = (count != '0);
    assign credit_full_o  = (count == MAX_VAL);
    assign credit_crit_o  = (count <= CRIT_VAL);

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= MAX_VAL)
        else $error("credit_counter: count above NUM_CREDITS");

    a_take_avail : assert property (@(posedge clk_i) disable iff (!rst_ni)
        credit_take_i |-> credit_avail_o)
        else $warning("credit_counter: take while no credit available");
`endif

endmodule

// File: tb/tb_credit_counter.sv
module tb_credit_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       clear = 1'b0, take = 1'b0, give = 1'b0;
    logic [3:0] left;
    logic       avail, full, crit, err_u, err_o;

    logic       clear0 = 1'b0, take0 = 1'b0, give0 = 1'b0;
    logic [3:0] left0;
    logic       avail0, full0, crit0, err_u0, err_o0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    credit_counter #(.NUM_CREDITS(8), .INIT_FULL(1'b1), .CRIT_LEVEL(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .credit_take_i(take), .credit_give_i(give),
        .credit_left_o(left), .credit_avail_o(avail), .credit_full_o(full),
        .credit_crit_o(crit), .err_underflow_o(err_u), .err_overflow_o(err_o)
    );

    credit_counter #(.NUM_CREDITS(8), .INIT_FULL(1'b0), .CRIT_LEVEL(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear0),
        .credit_take_i(take0), .credit_give_i(give0),
        .credit_left_o(left0), .credit_avail_o(avail0), .credit_full_o(full0),
        .credit_crit_o(crit0), .err_underflow_o(err_u0), .err_overflow_o(err_o0)
    );

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (left !== 4'd8) begin n_fail++; $display("FAIL reset_left got %0d exp 8", left); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL reset_full got %b exp 1", full); end
        n_checks++; if (avail !== 1'b1) begin n_fail++; $display("FAIL reset_avail got %b exp 1", avail); end
        n_checks++; if (crit !== 1'b0) begin n_fail++; $display("FAIL reset_crit got %b exp 0", crit); end
        n_checks++; if (err_u !== 1'b0 || err_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_err got u=%b o=%b exp 0 0", err_u, err_o); end
        n_checks++; if (left0 !== 4'd0 || avail0 !== 1'b0 || crit0 !== 1'b1)
            begin n_fail++; $display("FAIL reset0 got left=%0d avail=%b crit=%b exp 0 0 1", left0, avail0, crit0); end
    endtask

    task automatic test_take_down();
        for (int i = 0; i < 8; i++) begin
            take = 1'b1;
            tick();
            n_checks++; if (left !== 4'(7 - i)) begin n_fail++; $display("FAIL take_left[%0d] got %0d exp %0d", i, left, 7 - i); end
            n_checks++; if (crit !== ((7 - i) <= 1)) begin n_fail++; $display("FAIL take_crit[%0d] got %b exp %b", i, crit, ((7 - i) <= 1)); end
            n_checks++; if (avail !== (i != 7)) begin n_fail++; $display("FAIL take_avail[%0d] got %b exp %b", i, avail, (i != 7)); end
        end
        take = 1'b0;
        n_checks++; if (err_u !== 1'b0) begin n_fail++; $display("FAIL take_no_err got %b exp 0", err_u); end
    endtask

    task automatic test_take_give_bounds();
        // At 0: take and give together cancel, no underflow.
        take = 1'b1; give = 1'b1;
        tick();
        take = 1'b0; give = 1'b0;
        n_checks++; if (left !== 4'd0 || err_u !== 1'b0)
            begin n_fail++; $display("FAIL tg_zero got left=%0d u=%b exp 0 0", left, err_u); end
        // 9th take at 0 saturates and raises underflow.
        take = 1'b1;
        tick();
        take = 1'b0;
        n_checks++; if (left !== 4'd0 || err_u !== 1'b1)
            begin n_fail++; $display("FAIL underflow got left=%0d u=%b exp 0 1", left, err_u); end
        tick();
        n_checks++; if (err_u !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got %b exp 1", err_u); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (left !== 4'd8 || err_u !== 1'b0 || full !== 1'b1)
            begin n_fail++; $display("FAIL clear_full got left=%0d u=%b full=%b exp 8 0 1", left, err_u, full); end
        // At full: take and give together cancel, no overflow.
        take = 1'b1; give = 1'b1;
        tick();
        take = 1'b0; give = 1'b0;
        n_checks++; if (left !== 4'd8 || err_o !== 1'b0)
            begin n_fail++; $display("FAIL tg_full got left=%0d o=%b exp 8 0", left, err_o); end
    endtask

    task automatic test_overflow();
        give = 1'b1;
        tick();
        give = 1'b0;
        n_checks++; if (left !== 4'd8 || err_o !== 1'b1)
            begin n_fail++; $display("FAIL overflow got left=%0d o=%b exp 8 1", left, err_o); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky[%0d] got %b exp 1", i, err_o); end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (left !== 4'd8 || err_o !== 1'b0)
            begin n_fail++; $display("FAIL overflow_clear got left=%0d o=%b exp 8 0", left, err_o); end
    endtask

    task automatic test_clear_take();
        give0 = 1'b1;
        tick(); tick(); tick();
        give0 = 1'b0;
        n_checks++; if (left0 !== 4'd3) begin n_fail++; $display("FAIL init0_give got %0d exp 3", left0); end
        clear0 = 1'b1; take0 = 1'b1;
        tick();
        clear0 = 1'b0; take0 = 1'b0;
        n_checks++; if (left0 !== 4'd0 || err_u0 !== 1'b0)
            begin n_fail++; $display("FAIL clear_take got left=%0d u=%b exp 0 0", left0, err_u0); end
        tick();
        n_checks++; if (err_u0 !== 1'b0) begin n_fail++; $display("FAIL clear_take_late got u=%b exp 0", err_u0); end
    endtask

    task automatic test_async_reset();
        take = 1'b1;
        tick(); tick(); tick();
        take = 1'b0;
        n_checks++; if (left !== 4'd5) begin n_fail++; $display("FAIL pre_burst got %0d exp 5", left); end
        give = 1'b1;
        tick();
        n_checks++; if (left !== 4'd6) begin n_fail++; $display("FAIL burst_give got %0d exp 6", left); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (left !== 4'd8 || full !== 1'b1 || avail !== 1'b1 || crit !== 1'b0)
            begin n_fail++; $display("FAIL async_rst got left=%0d full=%b avail=%b crit=%b exp 8 1 1 0", left, full, avail, crit); end
        tick();
        give = 1'b0;
        n_checks++; if (left !== 4'd8) begin n_fail++; $display("FAIL rst_hold got %0d exp 8", left); end
        rst_n = 1'b1;
        take = 1'b1;
        tick();
        take = 1'b0;
        n_checks++; if (left !== 4'd7 || err_u !== 1'b0 || err_o !== 1'b0)
            begin n_fail++; $display("FAIL resume got left=%0d u=%b o=%b exp 7 0 0", left, err_u, err_o); end
    endtask

    initial begin
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_take_down();
        test_take_give_bounds();
        test_overflow();
        test_clear_take();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/credit_counter.md
Name: credit_counter

Overview:
Consumer-side tracker for credit-based flow control, counterpart to a producer that emits events and counts them.
- Holds the number of credits available to a sender.
- Decrements when the sender takes a credit; increments when the receiver returns one.
- Flags empty, full and critical levels, and latches protocol errors (overdraw, overfill).

Parameters:
NUM_CREDITS, 8, maximum credits held; must be >= 1.
INIT_FULL, 1'b1, 1: counter resets and re-inits to NUM_CREDITS; 0: to 0.
CRIT_LEVEL, 1, credit_crit_o asserts when count <= CRIT_LEVEL; must be < NUM_CREDITS.
CNT_WIDTH, $clog2(NUM_CREDITS+1), derived; width of the credit count; not to be overridden.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
clear_i  input  1  synchronous re-init to the init value; clears error flags.
credit_take_i  input  1  sender consumes one credit this cycle.
credit_give_i  input  1  receiver returns one credit this cycle.
credit_left_o  output  CNT_WIDTH  current credit count (registered).
credit_avail_o  output  1  count != 0; sender may take this cycle.
credit_full_o  output  1  count == NUM_CREDITS.
credit_crit_o  output  1  count <= CRIT_LEVEL.
err_underflow_o  output  1  sticky: a take occurred with count 0 and no same-cycle give.
err_overflow_o  output  1  sticky: a give occurred with count NUM_CREDITS and no same-cycle take.

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_ni).
- Reset values:
  - count = INIT_FULL ? NUM_CREDITS : 0.
  - Error flags = 0.
  - Status outputs follow from the count: credit_avail_o, credit_full_o and credit_crit_o are combinational decodes of the count register.
- Update rule, evaluated each rising edge, priority order:
  1. clear_i=1 -> count = init value, both error flags cleared. Takes and gives in that cycle are ignored.
  2. take & give -> count unchanged, no error, even when count is 0 or NUM_CREDITS.
  3. take only:
     - count > 0 -> count-1.
     - count == 0 -> count held at 0, err_underflow_o set.
  4. give only:
     - count < NUM_CREDITS -> count+1.
     - count == NUM_CREDITS -> count held, err_overflow_o set.
  5. Neither -> hold.
- Latency: a take or give is visible on credit_left_o and the status outputs one cycle after the edge that samples it.
- credit_avail_o is not combinationally forwarded from a same-cycle give; the sender sees returned credits one cycle later.
- No wrap-around ever: the count saturates at 0 and at NUM_CREDITS. The error flags record the illegal event.
- Error flags are sticky; only rst_ni or clear_i clears them.
- Reset mid-operation: asynchronous assertion forces the reset values immediately, regardless of in-flight takes or gives.
- Arithmetic: unsigned, CNT_WIDTH bits. Compare against NUM_CREDITS cast to CNT_WIDTH.
- Elaboration assertions:
  - NUM_CREDITS >= 1.
  - CRIT_LEVEL < NUM_CREDITS.
- Simulation assertions, both disabled during reset:
  - credit_left_o <= NUM_CREDITS.
  - No take while !credit_avail_o (warning only).

Decomposition:
- No package required; all constants are module-local localparams:
  - INIT_VAL.
  - MAX_VAL cast to CNT_WIDTH.
- Single module, no sub-module.
- The generic up/down counter is unsuitable: it cannot increment and decrement in the same cycle, and it lacks saturation with error capture.

Test Plan:
- Reset with INIT_FULL=1, NUM_CREDITS=8 -> credit_left_o=8, credit_full_o=1, credit_avail_o=1, crit=0, errors=0.
- 8 consecutive takes from 8 -> count 7..0; crit asserts when count=1; avail drops in the cycle after the 8th take. A 9th take -> count stays 0, err_underflow_o=1 next cycle.
- Count=0: take+give in the same cycle -> count 0, no underflow. Count=8: take+give -> count 8, no overflow.
- Count=8, single give -> count 8, err_overflow_o=1. Flag stays set for 20 idle cycles, then clear_i -> count=8, flag=0.
- clear_i with take=1 at count=3 (INIT_FULL=0 build) -> count=0, take ignored, no underflow.
- Assert rst_ni asynchronously mid-cycle during a burst of gives at count=5 -> outputs reach reset values before the next edge. Release -> counting resumes from the init value.
